// File: rtl/dct_requantizer.sv
`default_nettype none
// ============================================================================
// dct_requantizer: 2-stage round + range-check of N_CH fixed-point DCT coefs.
// Optional clamping of overflowed channels via DCT_REQUANT_SAT_EN.  Rev 1.0
// ============================================================================
module dct_requantizer #(
  parameter int N_CH   = 8,
  parameter int IN_W   = 19,
  parameter int FRAC_W = 7,
  parameter int OUT_W  = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_CH*IN_W-1:0]    in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_CH*OUT_W-1:0]   out_data,
  output logic [N_CH-1:0]         out_ovf,
  output logic [15:0]             ovf_count,
  input  logic                    ovf_clr
);

  localparam int c_rw = IN_W + 1 - FRAC_W;
  localparam logic [IN_W:0] c_half = (IN_W+1)'(2**(FRAC_W-1));
  localparam logic signed [c_rw-1:0] c_max = c_rw'(2**(OUT_W-1) - 1);
  localparam logic signed [c_rw-1:0] c_min = c_rw'(-(2**(OUT_W-1)));

  logic                            r_s1_valid;
  logic [N_CH-1:0][c_rw-1:0]       r_s1_r;
  logic                            r_s2_valid;
  logic [N_CH-1:0][OUT_W-1:0]      r_out_data;
  logic [N_CH-1:0]                 r_out_ovf;
  logic [15:0]                     r_ovf_count;

  logic                            w_s2_load;
  logic                            w_s1_load;
  logic                            w_out_fire;
  logic [N_CH-1:0][c_rw-1:0]       w_r;
  logic [N_CH-1:0][OUT_W-1:0]      w_q;
  logic [N_CH-1:0]                 w_ovf;

  // One guard bit keeps the +half addition from wrapping at the positive limit.
  function automatic logic [c_rw-1:0] f_round(input logic [IN_W-1:0] x);
    logic [IN_W:0] s;
    s = {x[IN_W-1], x} + c_half;
    return s[IN_W:FRAC_W];
  endfunction

  assign w_s2_load  = !r_s2_valid || out_ready;
  assign w_s1_load  = !r_s1_valid || w_s2_load;
  assign w_out_fire = r_s2_valid && out_ready;

  always_comb begin
    w_r = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_r[k] = f_round(in_data[k*IN_W +: IN_W]);
    end
  end

  always_comb begin
    w_q   = '0;
    w_ovf = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_ovf[k] = ($signed(r_s1_r[k]) > c_max) || ($signed(r_s1_r[k]) < c_min);
`ifdef DCT_REQUANT_SAT_EN
      if ($signed(r_s1_r[k]) > c_max)
        w_q[k] = {1'b0, {(OUT_W-1){1'b1}}};
      else if ($signed(r_s1_r[k]) < c_min)
        w_q[k] = {1'b1, {(OUT_W-1){1'b0}}};
      else
        w_q[k] = r_s1_r[k][OUT_W-1:0];
`else
      w_q[k] = r_s1_r[k][OUT_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_r     <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) r_s1_r <= w_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_out_data <= '0;
      r_out_ovf  <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_q;
        r_out_ovf  <= w_ovf;
      end
    end
  end

  // Clear has priority over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ovf_count <= '0;
    else if (ovf_clr)
      r_ovf_count <= '0;
    else if (w_out_fire && (|r_out_ovf) && (r_ovf_count != 16'hFFFF))
      r_ovf_count <= r_ovf_count + 16'd1;
  end

  assign in_ready  = w_s1_load;
  assign out_valid = r_s2_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;
  assign ovf_count = r_ovf_count;

endmodule
`default_nettype wire

// File: tb/tb_dct_requantizer.sv
`default_nettype none
// ============================================================================
// tb_dct_requantizer: scoreboard bench for dct_requantizer.  Rev 1.0
// ============================================================================
module tb_dct_requantizer;

  localparam int N_CH   = 8;
  localparam int IN_W   = 19;
  localparam int FRAC_W = 7;
  localparam int OUT_W  = 12;

  typedef struct packed {
    logic [N_CH*OUT_W-1:0] d;
    logic [N_CH-1:0]       ovf;
  } beat_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   out_ready = 1'b1;
  logic                   ovf_clr = 1'b0;
  logic [N_CH*IN_W-1:0]   in_data = '0;
  logic                   in_ready;
  logic                   out_valid;
  logic [N_CH*OUT_W-1:0]  out_data;
  logic [N_CH-1:0]        out_ovf;
  logic [15:0]            ovf_count;

  beat_t                  q[$];
  int                     n_pass = 0;
  int                     n_chk = 0;
  int                     ready_mode = 0;
  logic [15:0]            exp_cnt = '0;
  logic                   prev_hold = 1'b0;
  logic [N_CH*OUT_W-1:0]  prev_d = '0;
  logic [N_CH-1:0]        prev_ovf = '0;

  dct_requantizer #(.N_CH(N_CH), .IN_W(IN_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .ovf_count(ovf_count), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: floor((x + half) / 2^FRAC_W) via explicit sign handling.
  function automatic beat_t model(input logic [N_CH*IN_W-1:0] x);
    beat_t b;
    logic signed [IN_W-1:0] xs;
    int t, r, o, lim, dv;
    logic [31:0] ob;
    b   = '0;
    lim = 1 << (OUT_W-1);
    dv  = 1 << FRAC_W;
    for (int k = 0; k < N_CH; k++) begin
      xs = x[k*IN_W +: IN_W];
      t  = int'(xs) + (dv / 2);
      r  = (t >= 0) ? (t / dv) : -((-t + dv - 1) / dv);
      b.ovf[k] = (r > lim - 1) || (r < -lim);
`ifdef DCT_REQUANT_SAT_EN
      o = (r > lim - 1) ? lim - 1 : (r < -lim) ? -lim : r;
`else
      o = r;
`endif
      ob = 32'(o);
      b.d[k*OUT_W +: OUT_W] = ob[OUT_W-1:0];
    end
    return b;
  endfunction

  function automatic logic [N_CH*IN_W-1:0] splat(input int v);
    logic [N_CH*IN_W-1:0] x;
    for (int k = 0; k < N_CH; k++) x[k*IN_W +: IN_W] = IN_W'(v);
    return x;
  endfunction

  always @(posedge clk) begin
    #1;
    if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: protocol checks, scoreboard pop on output transfer, push on input transfer.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
      chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
      chk("rst_out_data", 128'(out_data), 128'(0));
      chk("rst_out_ovf", 128'(out_ovf), 128'(0));
      chk("rst_ovf_count", 128'(ovf_count), 128'(0));
      exp_cnt   = '0;
      prev_hold = 1'b0;
    end else begin
      chk("in_ready", 128'(in_ready), 128'((q.size() < 2) || out_ready));
      chk("ovf_count", 128'(ovf_count), 128'(exp_cnt));
      if (prev_hold) begin
        chk("hold_data", 128'(out_data), 128'(prev_d));
        chk("hold_ovf", 128'(out_ovf), 128'(prev_ovf));
      end
      prev_hold = out_valid && !out_ready;
      prev_d    = out_data;
      prev_ovf  = out_ovf;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_beat", 128'(out_valid), 128'(1'b0));
        end else begin
          e = q.pop_front();
          chk("out_data", 128'(out_data), 128'(e.d));
          chk("out_ovf", 128'(out_ovf), 128'(e.ovf));
          if (!ovf_clr && (|e.ovf) && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
      end
      if (ovf_clr) exp_cnt = '0;
      if (in_valid && in_ready) q.push_back(model(in_data));
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [N_CH*IN_W-1:0] d);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 128'(in_ready), 128'(1'b1));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic set_ready(input int m);
    #2;
    ready_mode = m;
    if (m == 0) out_ready = 1'b1;
    if (m == 2) out_ready = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 128'(q.size()), 128'(0));
  endtask

  initial begin
    logic [N_CH*IN_W-1:0] d;
    int vals[N_CH];
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Rounding cases and 2-cycle latency, first beat right after reset release.
    vals = '{256, 192, -192, 63, -64, 256, 192, -192};
    for (int k = 0; k < N_CH; k++) d[k*IN_W +: IN_W] = IN_W'(vals[k]);
    send(d);
    chk("lat_cycle1", 128'(out_valid), 128'(1'b0));
    @(posedge clk); #1;
    chk("lat_cycle2", 128'(out_valid), 128'(1'b1));
    chk("round_data", 128'(out_data),
        128'({12'hFFF, 12'h002, 12'h002, 12'h000, 12'h000, 12'hFFF, 12'h002, 12'h002}));
    chk("round_ovf", 128'(out_ovf), 128'(0));
    for (int i = 0; i < 4; i++) send(splat(i * 100 - 150));
    drain();

    // Positive overflow on channel 3.
    d = splat(0);
    d[3*IN_W +: IN_W] = 19'h3FFFF;
    send(d);
    @(posedge clk); #1;
    chk("ovf_flag", 128'(out_ovf), 128'(8'h08));
`ifdef DCT_REQUANT_SAT_EN
    chk("ovf_ch3", 128'(out_data[3*OUT_W +: OUT_W]), 128'(12'h7FF));
`else
    chk("ovf_ch3", 128'(out_data[3*OUT_W +: OUT_W]), 128'(12'h800));
`endif
    @(posedge clk); #1;
    chk("ovf_count_1", 128'(ovf_count), 128'(16'd1));

    // Most negative input lands exactly on the lower bound.
    send(splat(-262144));
    @(posedge clk); #1;
    chk("neg_data", 128'(out_data), 128'({8{12'h800}}));
    chk("neg_ovf", 128'(out_ovf), 128'(0));
    @(posedge clk); #1;
    chk("neg_count", 128'(ovf_count), 128'(16'd1));
    drain();

    // Random stream under random backpressure.
    set_ready(1);
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < N_CH; k++) d[k*IN_W +: IN_W] = IN_W'($urandom);
      if (i == 7) d[0 +: IN_W] = 19'h3FFFF;
      send(d);
    end
    set_ready(0);
    drain();

    // Reset with two beats in flight.
    @(posedge clk); #1;
    set_ready(2);
    send(splat(1000));
    send(splat(-1000));
    rst_n = 1'b0;
    #1;
    chk("rst_flush_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_flush_ready", 128'(in_ready), 128'(1'b1));
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    set_ready(0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("no_stale", 128'(out_valid), 128'(1'b0));
    end

    // Saturate the overflow counter with a long overflowing stream.
    d = splat(0);
    d[5*IN_W +: IN_W] = 19'h3FFFF;
    in_data  = d;
    in_valid = 1'b1;
    repeat (65540) @(posedge clk);
    #1 in_valid = 1'b0;
    drain();
    chk("count_sat", 128'(ovf_count), 128'(16'hFFFF));

    // Clear coincident with an overflowing output transfer.
    @(posedge clk); #1;
    set_ready(2);
    send(d);
    @(posedge clk); #1;
    chk("clr_pre_valid", 128'(out_valid), 128'(1'b1));
    chk("clr_pre_count", 128'(ovf_count), 128'(16'hFFFF));
    set_ready(0);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("clr_wins", 128'(ovf_count), 128'(16'd0));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
